// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-addressed, big-endian 16-bit data memory.
// Sequences READ/WRITE strobes, does read-modify-write for byte stores, and returns a one-cycle response.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_BYTES  = 128
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic                  ReqByte,
    input  logic                  ReqSigned,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0] ReqWData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] RespData,
    output logic                  RespError,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWriteData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemReadData
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic                  op_write;
    logic                  op_byte;
    logic                  op_signed;
    logic                  lane_low;
    logic                  accept;
    logic                  req_error;
    logic                  req_last_byte;
    logic [ADDR_WIDTH-1:0] max_word_addr;
    logic [ADDR_WIDTH-1:0] max_byte_addr;
    logic [7:0]            sel_byte;
    logic [DATA_WIDTH-1:0] load_byte;

    assign max_word_addr = ADDR_WIDTH'(MEM_BYTES - 2);
    assign max_byte_addr = ADDR_WIDTH'(MEM_BYTES - 1);

    assign ReqReady  = !Reset && (state == IDLE);
    assign MemRead   = !Reset && (state == READ);
    assign MemWrite  = !Reset && (state == WRITE);
    assign RespValid = (state == RESP);
    assign accept    = ReqValid && ReqReady;

    // The last byte is reached through the low lane of the word below it,
    // so the memory's second byte address never leaves the array.
    assign req_last_byte = ReqByte && (ReqAddr == max_byte_addr);
    assign req_error     = ReqByte ? (ReqAddr > max_byte_addr) : (ReqAddr > max_word_addr);

    always_comb begin
        sel_byte  = lane_low ? MemReadData[7:0] : MemReadData[15:8];
        load_byte = {{(DATA_WIDTH-8){op_signed & sel_byte[7]}}, sel_byte};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= IDLE;
            op_write     <= 1'b0;
            op_byte      <= 1'b0;
            op_signed    <= 1'b0;
            lane_low     <= 1'b0;
            RespData     <= '0;
            RespError    <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_write     <= ReqWrite;
                        op_byte      <= ReqByte;
                        op_signed    <= ReqSigned;
                        lane_low     <= req_last_byte;
                        MemAddress   <= req_last_byte ? (ReqAddr - ADDR_WIDTH'(1)) : ReqAddr;
                        MemWriteData <= ReqWData;
                        if (req_error) begin
                            RespError <= 1'b1;
                            RespData  <= '0;
                            state     <= RESP;
                        end else if (ReqWrite && !ReqByte) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (op_write) begin
                        // Byte store: merge the latched store byte into the word just read.
                        MemWriteData <= lane_low ? {MemReadData[DATA_WIDTH-1:8], MemWriteData[7:0]}
                                                 : {MemWriteData[7:0], MemReadData[7:0]};
                        state        <= WRITE;
                    end else begin
                        RespData  <= op_byte ? load_byte : MemReadData;
                        RespError <= 1'b0;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    RespData  <= '0;
                    RespError <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a 128-byte big-endian memory model.
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic        ReqByte;
    logic        ReqSigned;
    logic [15:0] ReqAddr;
    logic [15:0] ReqWData;
    logic        RespValid;
    logic [15:0] RespData;
    logic        RespError;
    logic [15:0] MemAddress;
    logic [15:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [15:0] MemReadData;

    logic [7:0]  mem [0:127];
    int          compared   = 0;
    int          mismatched = 0;
    int          pulses     = 0;
    int          lat;
    int          n_read;
    int          n_write;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    always #5 Clock = ~Clock;

    mem_access_unit #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(16),
        .MEM_BYTES (128)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .ReqValid    (ReqValid),
        .ReqReady    (ReqReady),
        .ReqWrite    (ReqWrite),
        .ReqByte     (ReqByte),
        .ReqSigned   (ReqSigned),
        .ReqAddr     (ReqAddr),
        .ReqWData    (ReqWData),
        .RespValid   (RespValid),
        .RespData    (RespData),
        .RespError   (RespError),
        .MemAddress  (MemAddress),
        .MemWriteData(MemWriteData),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .MemReadData (MemReadData)
    );

    assign MemReadData = {mem[MemAddress[6:0]], mem[MemAddress[6:0] + 7'd1]};

    always @(posedge Clock) begin
        if (MemWrite) begin
            mem[MemAddress[6:0]]         <= MemWriteData[15:8];
            mem[MemAddress[6:0] + 7'd1]  <= MemWriteData[7:0];
        end
    end

    always @(negedge Clock) begin
        if (RespValid) pulses++;
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
            $error("%s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Drives one request, waits for acceptance, then runs to the response cycle
    // recording latency and strobe activity.
    task automatic issue(input string tag, input logic w, input logic b, input logic s,
                         input logic [15:0] a, input logic [15:0] d);
        int guard = 0;
        ReqWrite = w; ReqByte = b; ReqSigned = s; ReqAddr = a; ReqWData = d;
        ReqValid = 1'b1;
        while (!ReqReady && guard < 20) begin
            tick();
            guard++;
        end
        check({tag, " ready"}, 16'(ReqReady), 16'h1);
        tick();
        ReqValid = 1'b0;
        check({tag, " busy"}, 16'(ReqReady), 16'h0);
        lat = 1; n_read = 0; n_write = 0; wr_addr = 'x; wr_data = 'x;
        while (!RespValid && lat < 10) begin
            if (MemRead) n_read++;
            if (MemWrite) begin
                n_write++;
                wr_addr = MemAddress;
                wr_data = MemWriteData;
            end
            tick();
            lat++;
        end
    endtask

    task automatic end_resp(input string tag);
        tick();
        check({tag, " pulse1"}, 16'(RespValid), 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqByte = 1'b0;
        ReqSigned = 1'b0; ReqAddr = '0; ReqWData = '0;
        tick();
        tick();
        check("rst RespValid", 16'(RespValid), 16'h0);
        check("rst RespData", RespData, 16'h0);
        check("rst RespError", 16'(RespError), 16'h0);
        check("rst MemAddress", MemAddress, 16'h0);
        check("rst MemWriteData", MemWriteData, 16'h0);
        check("rst ReqReady", 16'(ReqReady), 16'h0);
        check("rst MemRead", 16'(MemRead), 16'h0);
        check("rst MemWrite", 16'(MemWrite), 16'h0);
        Reset = 1'b0;
        #1;
        check("post-rst ReqReady", 16'(ReqReady), 16'h1);

        // Word store then word load at 2
        issue("wst2", 1'b1, 1'b0, 1'b0, 16'd2, 16'h1234);
        check("wst2 lat", 16'(lat), 16'd2);
        check("wst2 err", 16'(RespError), 16'h0);
        check("wst2 data", RespData, 16'h0);
        check("wst2 nwrite", 16'(n_write), 16'd1);
        check("wst2 nread", 16'(n_read), 16'd0);
        check("wst2 waddr", wr_addr, 16'd2);
        check("wst2 wdata", wr_data, 16'h1234);
        end_resp("wst2");
        check("wst2 mem2", 16'(mem[2]), 16'h12);
        check("wst2 mem3", 16'(mem[3]), 16'h34);

        issue("wld2", 1'b0, 1'b0, 1'b1, 16'd2, 16'hFFFF);
        check("wld2 lat", 16'(lat), 16'd2);
        check("wld2 data", RespData, 16'h1234);
        check("wld2 err", 16'(RespError), 16'h0);
        check("wld2 nread", 16'(n_read), 16'd1);
        check("wld2 nwrite", 16'(n_write), 16'd0);
        end_resp("wld2");

        // Byte store 0xAB at 3 (high lane of word at 3)
        issue("bst3", 1'b1, 1'b1, 1'b0, 16'd3, 16'h00AB);
        check("bst3 lat", 16'(lat), 16'd3);
        check("bst3 nread", 16'(n_read), 16'd1);
        check("bst3 nwrite", 16'(n_write), 16'd1);
        check("bst3 waddr", wr_addr, 16'd3);
        check("bst3 wdata", wr_data, 16'hAB04);
        end_resp("bst3");
        check("bst3 mem2", 16'(mem[2]), 16'h12);
        check("bst3 mem3", 16'(mem[3]), 16'hAB);
        check("bst3 mem4", 16'(mem[4]), 16'h04);

        issue("bld3s", 1'b0, 1'b1, 1'b1, 16'd3, 16'h0);
        check("bld3s lat", 16'(lat), 16'd2);
        check("bld3s data", RespData, 16'hFFAB);
        end_resp("bld3s");
        issue("bld3u", 1'b0, 1'b1, 1'b0, 16'd3, 16'h0);
        check("bld3u data", RespData, 16'h00AB);
        end_resp("bld3u");
        issue("bld2s", 1'b0, 1'b1, 1'b1, 16'd2, 16'h0);
        check("bld2s data", RespData, 16'h0012);
        end_resp("bld2s");

        // Last byte goes through the low lane of word 126
        issue("bst127", 1'b1, 1'b1, 1'b0, 16'd127, 16'hFF5A);
        check("bst127 lat", 16'(lat), 16'd3);
        check("bst127 waddr", wr_addr, 16'd126);
        check("bst127 wdata", wr_data, 16'h7E5A);
        check("bst127 err", 16'(RespError), 16'h0);
        end_resp("bst127");
        check("bst127 mem126", 16'(mem[126]), 16'h7E);
        check("bst127 mem127", 16'(mem[127]), 16'h5A);
        issue("bld127", 1'b0, 1'b1, 1'b1, 16'd127, 16'h0);
        check("bld127 data", RespData, 16'h005A);
        end_resp("bld127");
        issue("wld126", 1'b0, 1'b0, 1'b0, 16'd126, 16'h0);
        check("wld126 data", RespData, 16'h7E5A);
        check("wld126 err", 16'(RespError), 16'h0);
        end_resp("wld126");

        // Range errors
        issue("wld127", 1'b0, 1'b0, 1'b0, 16'd127, 16'h0);
        check("wld127 lat", 16'(lat), 16'd1);
        check("wld127 err", 16'(RespError), 16'h1);
        check("wld127 data", RespData, 16'h0);
        check("wld127 nread", 16'(n_read), 16'd0);
        check("wld127 nwrite", 16'(n_write), 16'd0);
        end_resp("wld127");
        check("err hold", 16'(RespError), 16'h1);
        issue("bld128", 1'b0, 1'b1, 1'b0, 16'd128, 16'h0);
        check("bld128 err", 16'(RespError), 16'h1);
        check("bld128 lat", 16'(lat), 16'd1);
        end_resp("bld128");
        issue("wst127", 1'b1, 1'b0, 1'b0, 16'd127, 16'hDEAD);
        check("wst127 err", 16'(RespError), 16'h1);
        check("wst127 nwrite", 16'(n_write), 16'd0);
        end_resp("wst127");
        check("wst127 mem127", 16'(mem[127]), 16'h5A);
        issue("wst0", 1'b1, 1'b0, 1'b0, 16'd0, 16'h0102);
        check("wst0 err clr", 16'(RespError), 16'h0);
        end_resp("wst0");

        // Reset asserted during the WRITE cycle of a byte store
        ReqWrite = 1'b1; ReqByte = 1'b1; ReqSigned = 1'b0; ReqAddr = 16'd10; ReqWData = 16'h00C3;
        ReqValid = 1'b1;
        check("rstw ready", 16'(ReqReady), 16'h1);
        tick();
        ReqValid = 1'b0;
        check("rstw read", 16'(MemRead), 16'h1);
        tick();
        check("rstw write pre", 16'(MemWrite), 16'h1);
        Reset = 1'b1;
        #1;
        check("rstw write gated", 16'(MemWrite), 16'h0);
        tick();
        Reset = 1'b0;
        #1;
        check("rstw ReqReady", 16'(ReqReady), 16'h1);
        check("rstw RespValid", 16'(RespValid), 16'h0);
        check("rstw mem10", 16'(mem[10]), 16'h0A);
        check("rstw mem11", 16'(mem[11]), 16'h0B);

        // Back-to-back with ReqValid held high
        pulses = 0;
        ReqWrite = 1'b0; ReqByte = 1'b0; ReqSigned = 1'b0; ReqAddr = 16'd2; ReqWData = '0;
        ReqValid = 1'b1;
        check("b2b ready0", 16'(ReqReady), 16'h1);
        tick();
        check("b2b busy read", 16'(ReqReady), 16'h0);
        ReqWrite = 1'b1; ReqAddr = 16'd4; ReqWData = 16'hBEEF;
        tick();
        check("b2b resp1 valid", 16'(RespValid), 16'h1);
        check("b2b resp1 data", RespData, 16'h12AB);
        check("b2b busy resp", 16'(ReqReady), 16'h0);
        tick();
        check("b2b idle valid", 16'(RespValid), 16'h0);
        check("b2b idle ready", 16'(ReqReady), 16'h1);
        tick();
        ReqValid = 1'b0;
        check("b2b busy write", 16'(ReqReady), 16'h0);
        check("b2b memwrite", 16'(MemWrite), 16'h1);
        check("b2b waddr", MemAddress, 16'd4);
        check("b2b wdata", MemWriteData, 16'hBEEF);
        tick();
        check("b2b resp2 valid", 16'(RespValid), 16'h1);
        check("b2b resp2 data", RespData, 16'h0);
        tick();
        tick();
        tick();
        check("b2b pulses", 16'(pulses), 16'd2);
        check("b2b mem4", 16'(mem[4]), 16'hBE);
        check("b2b mem5", 16'(mem[5]), 16'hEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side load/store initiator for the 16-bit CPU's byte-addressed, big-endian 16-bit data memory.
- Accepts one load/store request at a time over a valid/ready handshake and sequences the memory strobes.
- Byte stores are done as read-modify-write, because the memory only writes whole 16-bit words.
- Returns a one-cycle response pulse with the load data or an error flag.

Parameters:
- ADDR_WIDTH, 16, width of byte address.
- DATA_WIDTH, 16, width of data word (fixed two byte lanes).
- MEM_BYTES, 128, size of data memory in bytes; used for range checks.

Ports:
- Clock  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high reset.
- ReqValid  input  1  request present.
- ReqReady  output  1  unit can accept a request this cycle.
- ReqWrite  input  1  1 = store, 0 = load.
- ReqByte  input  1  1 = byte access, 0 = word access.
- ReqSigned  input  1  byte load: 1 = sign-extend, 0 = zero-extend.
- ReqAddr  input  ADDR_WIDTH  byte address.
- ReqWData  input  DATA_WIDTH  store data; byte store uses [7:0].
- RespValid  output  1  one-cycle response pulse.
- RespData  output  DATA_WIDTH  load result; 0 for stores and errors.
- RespError  output  1  out-of-range access, valid with RespValid.
- MemAddress  output  ADDR_WIDTH  to memory Address.
- MemWriteData  output  DATA_WIDTH  to memory WriteData.
- MemWrite  output  1  to memory MemWrite; memory commits on posedge.
- MemRead  output  1  to memory MemRead.
- MemReadData  input  DATA_WIDTH  from memory ReadData; combinational, same cycle.

Behaviour:
- Reset values: state IDLE; RespValid 0, RespData 0, RespError 0, MemAddress 0, MemWriteData 0.
- MemWrite, MemRead and ReqReady are decoded from state and gated by !Reset, so they are 0 in any cycle where Reset is high.
- ReqReady = 1 only in IDLE. A request is accepted on a posedge with ReqValid & ReqReady; all request fields are latched then.
- States:
  - IDLE
  - READ: MemRead=1; MemReadData registered at the end of this cycle.
  - WRITE: MemWrite=1 for exactly one cycle.
  - RESP: RespValid=1 for one cycle, then IDLE.
- Transitions from IDLE:
  - word load -> READ -> RESP
  - word store -> WRITE -> RESP
  - byte load -> READ -> RESP
  - byte store -> READ -> WRITE -> RESP
  - range error -> RESP, with no memory strobes.
- Latency, counted from the acceptance edge: RespValid appears 2 cycles later for word load, word store and byte load; 3 cycles later for byte store; 1 cycle later for errors.
- Range check:
  - word access errors if ReqAddr > MEM_BYTES-2.
  - byte access errors if ReqAddr > MEM_BYTES-1.
  - On error: RespError=1, RespData=0.
- Word access: MemAddress=ReqAddr. Big-endian: MemWriteData=ReqWData, RespData=MemReadData.
- Byte lane select:
  - If ReqAddr < MEM_BYTES-1: base=ReqAddr, lane=high [15:8].
  - If ReqAddr == MEM_BYTES-1: base=ReqAddr-1, lane=low [7:0]. This keeps the memory's Address+1 inside the array.
- Byte load: RespData = selected byte, sign- or zero-extended per ReqSigned. Word load ignores ReqSigned.
- Byte store: write word = read word with the selected lane replaced by ReqWData[7:0]; the other lane is preserved.
- MemAddress and MemWriteData are held stable for the whole READ/WRITE sequence; they are don't-care in IDLE/RESP but must not glitch during WRITE.
- RespData and RespError hold their last value until the next RESP.
- No response backpressure: RespValid is never stretched.
- Reset mid-operation: next edge goes to IDLE. A WRITE cycle with Reset high writes nothing (strobe gated). A write committed on an earlier edge stays.
- Back-to-back: ReqValid held high gets the next request accepted in the first IDLE cycle after RespValid.

Test Plan:
- Word store 0x1234 at addr 2, then word load at addr 2 -> mem[2]=0x12, mem[3]=0x34; RespData=0x1234; RespValid 2 cycles after each acceptance; RespError=0.
- Preload mem[2]=0x12, mem[3]=0x34; byte store ReqWData=0x00AB at addr 3 -> one READ cycle, then one WRITE cycle with MemAddress=3, MemWriteData=0xAB00|mem[4]; mem[3]=0xAB, mem[2] and mem[4] unchanged; RespValid at cycle 3.
- mem[3]=0xAB: byte load addr 3 with ReqSigned=1 -> RespData=0xFFAB; with ReqSigned=0 -> 0x00AB.
- Boundary, MEM_BYTES=128:
  - byte store 0x5A at addr 127 -> MemAddress=126, MemWriteData={mem[126],0x5A}, mem[127]=0x5A.
  - word load at 127 -> RespError=1, RespData=0, MemRead/MemWrite never asserted, RespValid 1 cycle after acceptance.
- Reset high during the WRITE cycle of a byte store to addr 10 -> MemWrite stays 0, mem[10] unchanged; ReqReady=1 in the first cycle after Reset deasserts.
- ReqValid held high with a word load (addr 2) followed by a word store (addr 4) -> ReqReady=0 while busy; second request accepted the cycle after the first RespValid; exactly two RespValid pulses.
